// File: rtl/pi_loop_filter_gs_if.sv
// pi_loop_filter_gs_if: TED error in / NCO correction out bundle for the gear-shift PI loop filter.
interface pi_loop_filter_gs_if #(parameter int WERR = 18);
    logic signed [WERR-1:0] e_in_i;
    logic                   e_valid_i;
    logic                   hold_i;
    logic                   int_clr_i;
    logic                   force_acq_i;
    logic signed [WERR-1:0] ctrl_o;
    logic                   ctrl_val_o;
    logic                   locked_o;
    logic                   sat_o;
    logic signed [WERR-1:0] err_avg_o;
    modport master (
        output e_in_i, e_valid_i, hold_i, int_clr_i, force_acq_i,
        input  ctrl_o, ctrl_val_o, locked_o, sat_o, err_avg_o
    );
    modport slave (
        input  e_in_i, e_valid_i, hold_i, int_clr_i, force_acq_i,
        output ctrl_o, ctrl_val_o, locked_o, sat_o, err_avg_o
    );
endinterface

// File: rtl/pi_loop_filter_gs.sv
// pi_loop_filter_gs: gear-shift PI loop filter with ACQ/TRACK lock FSM, deadband and clamped integrator.
// Define PI_LF_ERR_AVG_EN to build the 256-strobe mean |e| output on err_avg_o.
module pi_loop_filter_gs #(
    parameter int WERR       = 18,
    parameter int ACC_WIDTH  = 24,
    parameter int KP_ACQ     = 5,
    parameter int KI_ACQ     = 9,
    parameter int KP_TRK     = 7,
    parameter int KI_TRK     = 12,
    parameter int DB_THR     = 127,
    parameter int INT_LIM    = 131071,
    parameter int LOCK_THR   = 512,
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_THR = 4096,
    parameter int UNLOCK_CNT = 16
) (
    input logic                clk,
    input logic                reset_n,
    pi_loop_filter_gs_if.slave lf
);
    localparam int SW   = ACC_WIDTH + 2;
    localparam int LCW  = $clog2(LOCK_CNT) + 1;
    localparam int UCW  = $clog2(UNLOCK_CNT) + 1;
    localparam int CMAX = 2 ** (WERR - 1) - 1;

    typedef enum logic {ACQ, TRACK} state_t;

    state_t                  state, state_nx;
    logic [LCW-1:0]          lock_cnt, lock_cnt_nx;
    logic [UCW-1:0]          unlock_cnt, unlock_cnt_nx;
    logic signed [ACC_WIDTH-1:0] acc, acc_nx;
    logic signed [WERR:0]    e_ext, abs_e, e_eff;
    logic signed [SW-1:0]    prop, iterm, acc_sum, ctrl_sum;
    logic signed [WERR-1:0]  ctrl_nx;
    logic                    clamp_hit, integrate;

    // Symmetric round-half-up on magnitude, so positive and negative errors get equal gain.
    function automatic logic signed [SW-1:0] rs(input logic signed [WERR:0] x, input int s);
        logic [SW-1:0] mag, r;
        mag = SW'(x < 0 ? -x : x);
        if (s == 0) r = mag;
        else r = (mag + (SW'(1) << (s - 1))) >> s;
        return x < 0 ? -$signed(r) : $signed(r);
    endfunction

    always_comb begin
        e_ext     = (WERR+1)'(lf.e_in_i);
        abs_e     = e_ext < 0 ? -e_ext : e_ext;
        e_eff     = abs_e <= DB_THR ? '0 : e_ext;
        prop      = state == TRACK ? rs(e_eff, KP_TRK) : rs(e_eff, KP_ACQ);
        iterm     = state == TRACK ? rs(e_eff, KI_TRK) : rs(e_eff, KI_ACQ);
        acc_sum   = SW'(acc) + iterm;
        integrate = lf.e_valid_i && !lf.hold_i && !lf.int_clr_i;
        clamp_hit = integrate && (acc_sum > INT_LIM || acc_sum < -INT_LIM);
        acc_nx    = lf.int_clr_i ? '0 :
                    !integrate ? acc :
                    acc_sum > INT_LIM ? ACC_WIDTH'(INT_LIM) :
                    acc_sum < -INT_LIM ? ACC_WIDTH'(-INT_LIM) : ACC_WIDTH'(acc_sum);
        ctrl_sum  = prop + SW'(acc_nx);
        ctrl_nx   = ctrl_sum > CMAX ? WERR'(CMAX) :
                    ctrl_sum < -CMAX - 1 ? WERR'(-CMAX - 1) : WERR'(ctrl_sum);
    end

    // Lock detector looks at raw |e|, independent of the deadband.
    always_comb begin
        state_nx      = state;
        lock_cnt_nx   = lock_cnt;
        unlock_cnt_nx = unlock_cnt;
        if (lf.force_acq_i) begin
            state_nx      = ACQ;
            lock_cnt_nx   = '0;
            unlock_cnt_nx = '0;
        end else if (lf.e_valid_i && state == ACQ) begin
            lock_cnt_nx = abs_e >= LOCK_THR ? '0 :
                          lock_cnt == LCW'(LOCK_CNT) ? lock_cnt : lock_cnt + LCW'(1);
            if (lock_cnt_nx == LCW'(LOCK_CNT)) begin
                state_nx    = TRACK;
                lock_cnt_nx = '0;
            end
        end else if (lf.e_valid_i) begin
            unlock_cnt_nx = abs_e <= UNLOCK_THR ? '0 :
                            unlock_cnt == UCW'(UNLOCK_CNT) ? unlock_cnt : unlock_cnt + UCW'(1);
            if (unlock_cnt_nx == UCW'(UNLOCK_CNT)) begin
                state_nx      = ACQ;
                unlock_cnt_nx = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ACQ;
            lock_cnt      <= '0;
            unlock_cnt    <= '0;
            acc           <= '0;
            lf.ctrl_o     <= '0;
            lf.ctrl_val_o <= 1'b0;
            lf.sat_o      <= 1'b0;
        end else begin
            state         <= state_nx;
            lock_cnt      <= lock_cnt_nx;
            unlock_cnt    <= unlock_cnt_nx;
            acc           <= acc_nx;
            lf.ctrl_val_o <= lf.e_valid_i;
            lf.sat_o      <= lf.int_clr_i ? 1'b0 : lf.sat_o | clamp_hit;
            if (lf.e_valid_i) lf.ctrl_o <= ctrl_nx;
        end
    end

    assign lf.locked_o = state == TRACK;

`ifdef PI_LF_ERR_AVG_EN
    logic [WERR-1:0] hist [256];
    logic [WERR+7:0] sum;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum <= '0;
            for (int i = 0; i < 256; i++) hist[i] <= '0;
        end else if (lf.e_valid_i) begin
            sum     <= sum + (WERR+8)'(abs_e) - (WERR+8)'(hist[255]);
            hist[0] <= WERR'(abs_e);
            for (int i = 1; i < 256; i++) hist[i] <= hist[i-1];
        end
    end
    assign lf.err_avg_o = WERR'(sum >> 8);
`else
    assign lf.err_avg_o = '0;
`endif
endmodule

// File: tb/tb_pi_loop_filter_gs.sv
// tb_pi_loop_filter_gs: directed vectors against an integer reference of the PI filter,
// checked every cycle, plus hand-computed literals from the test plan.
module tb_pi_loop_filter_gs;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    int m_acc, m_ctrl, m_lc, m_uc;
    bit m_val, m_locked, m_sat;

    pi_loop_filter_gs_if #(.WERR(18)) lf();
    pi_loop_filter_gs dut (.clk(clk), .reset_n(reset_n), .lf(lf));

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int rs_m(int x, int s);
        int m = x < 0 ? -x : x;
        if (s == 0) return x;
        m = (m + (1 << (s - 1))) / (1 << s);
        return x < 0 ? -m : m;
    endfunction

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("ctrl_o", int'(lf.ctrl_o), m_ctrl);
            chk("ctrl_val_o", int'(lf.ctrl_val_o), int'(m_val));
            chk("locked_o", int'(lf.locked_o), int'(m_locked));
            chk("sat_o", int'(lf.sat_o), int'(m_sat));
            chk("err_avg_o", int'(lf.err_avg_o), 0);
        end
    end

    task automatic do_reset(input bit v);
        @(negedge clk);
        reset_n = 1'b0;
        lf.e_in_i = 18'sd1000;
        lf.e_valid_i = v;
        lf.hold_i = 1'b0;
        lf.int_clr_i = 1'b0;
        lf.force_acq_i = 1'b0;
        m_acc = 0; m_ctrl = 0; m_lc = 0; m_uc = 0;
        m_val = 0; m_locked = 0; m_sat = 0;
        chk_en = 1'b1;
    endtask

    task automatic step(input int e, input bit v = 1, input bit hold = 0,
                        input bit clr = 0, input bit frc = 0);
        int ae, eff, na, c;
        @(negedge clk);
        reset_n = 1'b1;
        lf.e_in_i = 18'(e);
        lf.e_valid_i = v;
        lf.hold_i = hold;
        lf.int_clr_i = clr;
        lf.force_acq_i = frc;
        ae  = e < 0 ? -e : e;
        eff = ae <= 127 ? 0 : e;
        na  = m_acc;
        if (clr) na = 0;
        else if (v && !hold) begin
            na = m_acc + rs_m(eff, m_locked ? 12 : 9);
            if (na > 131071 || na < -131071) m_sat = 1;
            na = na > 131071 ? 131071 : na < -131071 ? -131071 : na;
        end
        if (v) begin
            c = rs_m(eff, m_locked ? 7 : 5) + na;
            m_ctrl = c > 131071 ? 131071 : c < -131072 ? -131072 : c;
        end
        m_acc = na;
        if (clr) m_sat = 0;
        m_val = v;
        if (frc) begin
            m_locked = 0; m_lc = 0; m_uc = 0;
        end else if (v && !m_locked) begin
            m_lc = ae < 512 ? m_lc + 1 : 0;
            if (m_lc == 64) begin m_locked = 1; m_lc = 0; end
        end else if (v) begin
            m_uc = ae > 4096 ? m_uc + 1 : 0;
            if (m_uc == 16) begin m_locked = 0; m_uc = 0; end
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        lf.e_in_i = '0; lf.e_valid_i = 0; lf.hold_i = 0; lf.int_clr_i = 0; lf.force_acq_i = 0;
        // reset state and first strobes
        do_reset(0);
        settle();
        chk("rst_ctrl", int'(lf.ctrl_o), 0);
        chk("rst_locked", int'(lf.locked_o), 0);
        step(1000);
        settle();
        chk("t1_pos_ctrl", int'(lf.ctrl_o), 33);
        chk("t1_pos_val", int'(lf.ctrl_val_o), 1);
        chk("t1_model_acc", m_acc, 2);
        step(0, 0);
        settle();
        chk("t1_val_one_cycle", int'(lf.ctrl_val_o), 0);
        do_reset(0);
        step(-1000);
        settle();
        chk("t1_neg_ctrl", int'(lf.ctrl_o), -33);
        // deadband
        do_reset(0);
        step(1000);
        step(100);
        settle();
        chk("t2_db100", int'(lf.ctrl_o), 2);
        step(-127);
        settle();
        chk("t2_db127", int'(lf.ctrl_o), 2);
        step(128);
        settle();
        chk("t2_e128", int'(lf.ctrl_o), 6);
        do_reset(0);
        step(-131072);
        settle();
        chk("t2_most_neg", int'(lf.ctrl_o), -4352);
        // integrator saturation with lock forced off
        do_reset(0);
        for (int i = 0; i < 511; i++) step(131071, 1, 0, 0, 1);
        settle();
        chk("t3_sat_before", int'(lf.sat_o), 0);
        chk("t3_model_acc511", m_acc, 130816);
        step(131071, 1, 0, 0, 1);
        settle();
        chk("t3_sat_after", int'(lf.sat_o), 1);
        chk("t3_ctrl_clamp", int'(lf.ctrl_o), 131071);
        step(0, 0, 0, 1);
        settle();
        chk("t3_sat_clr", int'(lf.sat_o), 0);
        step(1000);
        settle();
        chk("t3_acc_cleared", int'(lf.ctrl_o), 33);
        // lock acquisition and tracking gains
        do_reset(0);
        for (int i = 0; i < 63; i++) step(200);
        settle();
        chk("t4_no_lock_63", int'(lf.locked_o), 0);
        step(200);
        settle();
        chk("t4_lock_64", int'(lf.locked_o), 1);
        step(20000);
        settle();
        chk("t4_trk_gain", int'(lf.ctrl_o), 161);
        // unlock run broken by one small error
        step(0);
        for (int i = 0; i < 15; i++) step(5000);
        step(0);
        for (int i = 0; i < 15; i++) step(5000);
        settle();
        chk("t5_still_locked", int'(lf.locked_o), 1);
        step(5000);
        settle();
        chk("t5_unlock_16", int'(lf.locked_o), 0);
        step(1000, 1, 0, 1);
        settle();
        chk("t5_clr_strobe", int'(lf.ctrl_o), 31);
        do_reset(0);
        for (int i = 0; i < 63; i++) step(200);
        step(600);
        for (int i = 0; i < 63; i++) step(200);
        settle();
        chk("t4_broken_run", int'(lf.locked_o), 0);
        // hold, then reset mid-sequence with a strobe present
        do_reset(0);
        step(2000);
        for (int i = 0; i < 5; i++) step(2000, 1, 1);
        settle();
        chk("t6_hold_ctrl", int'(lf.ctrl_o), 67);
        do_reset(1);
        settle();
        chk("t6_rst_ctrl", int'(lf.ctrl_o), 0);
        chk("t6_rst_val", int'(lf.ctrl_val_o), 0);
        for (int i = 0; i < 10; i++) step(2000, 1, 1);
        settle();
        chk("t6_hold_after_rst", int'(lf.ctrl_o), 63);
        step(0, 0);
        step(0, 0);
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
